// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: eight-way round-robin arbiter driving an 8:1 bit mux.
// A requester keeps the grant for as long as it holds its req bit. When it
// drops req, the search for the next owner starts just past the old owner.
// Optional feature: define MUX8_ARB_TIMEOUT_EN to cap a tenure at HOLD_MAX
// GRANT cycles. On timeout the owner is released, the search runs as usual
// (the owner itself comes last), and preempt pulses for one cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req[7:0]    request per requester (bit i = requester i)
//   din[7:0]    one data bit per requester
//   gnt[7:0]    registered one-hot grant, zero when there is no owner
//   sel0..sel2  registered binary owner index (sel0 = LSB), held while idle
//   busy        registered, high while a requester owns the mux
//   out         din[{sel2,sel1,sel0}] while busy, else 0 (combinational)
//   preempt     registered one-cycle pulse on a timeout release
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic       sel0,
    output logic       sel1,
    output logic       sel2,
    output logic       busy,
    output logic       out,
    output logic       preempt
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject out-of-range hold limits at elaboration time.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("mux8_rr_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t             state, state_d;
    logic [IDX_W-1:0]   last, last_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   sel, sel_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               busy_d;
    logic               preempt_d;
    logic               timeout;
    logic               load;
    logic [IDX_W-1:0]   base;
    logic [IDX_W:0]     pick;

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    assign timeout = (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    // First set req bit after base, wrapping; base itself is checked last.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] b);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDX_W'(b + IDX_W'(k));
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // An owner hands off relative to itself; an idle arbiter uses last.
    assign base = (state == GRANT) ? owner : last;
    assign pick = rr_pick(req, base);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state;
        last_d    = last;
        owner_d   = owner;
        sel_d     = sel;
        gnt_d     = gnt;
        busy_d    = busy;
        preempt_d = 1'b0;
        load      = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (pick[IDX_W]) load = 1'b1;
            end
            GRANT: begin
                if (req[owner] && !timeout) begin
`ifdef MUX8_ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt + CNT_W'(1);
`endif
                end else begin
                    last_d = owner;
`ifdef MUX8_ARB_TIMEOUT_EN
                    // Still requesting here means the tenure timed out.
                    preempt_d = req[owner];
`endif
                    if (pick[IDX_W]) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
        if (load) begin
            state_d = GRANT;
            owner_d = pick[IDX_W-1:0];
            sel_d   = pick[IDX_W-1:0];
            gnt_d   = N_REQ'(1) << pick[IDX_W-1:0];
            busy_d  = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= IDX_W'(N_REQ - 1);
            owner   <= '0;
            sel     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_d;
            last    <= last_d;
            owner   <= owner_d;
            sel     <= sel_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
            preempt <= preempt_d;
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    // Tenure counter: cleared on each new grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_cnt <= '0;
        else       hold_cnt <= hold_cnt_d;
    end
`endif

    assign sel0 = sel[0];
    assign sel1 = sel[1];
    assign sel2 = sel[2];
    assign out  = busy ? din[sel] : 1'b0;

endmodule
